// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter slice.
// Also carries the debug view of the arbiter's internal conflict counter.
package dmem_arb_pkg;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 16;
  localparam int CNT_W      = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    PORT_CORE = 1'b0,
    PORT_HOST = 1'b1
  } port_e;

  // Debug hook: mirrors the conflict counter of the arbiter instance.
  logic [CNT_W-1:0] dbg_conflict_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Core port, host/loader port and data_memory side of the arbiter.
// slave = arbiter view, master = requesters + memory view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = dmem_arb_pkg::DEF_ADDR_W,
  parameter int DATA_W = dmem_arb_pkg::DEF_DATA_W
);
  logic              c_req, c_we, c_gnt, c_done;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata, c_rdata;

  logic              h_req, h_we, h_gnt, h_done;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_wdata, h_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_read, mem_write;

  logic              busy;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_gnt, c_done, c_rdata,
    input  h_req, h_we, h_addr, h_wdata,
    output h_gnt, h_done, h_rdata,
    output mem_addr, mem_wdata, mem_read, mem_write,
    input  mem_rdata,
    output busy
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_gnt, c_done, c_rdata,
    output h_req, h_we, h_addr, h_wdata,
    input  h_gnt, h_done, h_rdata,
    input  mem_addr, mem_wdata, mem_read, mem_write,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/dmem_arb_pick.sv
// Winner select between core and host. With DMEM_ARB_RR_EN defined a 1-bit
// priority pointer alternates simultaneous requests; otherwise core always wins.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  c_req,
  input  logic  h_req,
  input  logic  upd,      // high in ACCESS: the current owner has just been served
  input  port_e last,
  output port_e winner,
  output logic  any_req
);

  assign any_req = c_req | h_req;

`ifdef DMEM_ARB_RR_EN
  port_e prio;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= PORT_CORE;
    end else if (upd) begin
      prio <= (last == PORT_CORE) ? PORT_HOST : PORT_CORE;
    end
  end

  always_comb begin
    winner = PORT_CORE;
    if (c_req && h_req) begin
      winner = prio;
    end else if (h_req) begin
      winner = PORT_HOST;
    end
  end
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, clk, rst_n, upd, last};

  assign winner = (!c_req && h_req) ? PORT_HOST : PORT_CORE;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (core, host) arbiter in front of a single-port data_memory.
// Optional round-robin arbitration via the DMEM_ARB_RR_EN macro.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic            clk,
  input  logic            rst_n,
  dmem_arbiter_if.slave   bus
);

  state_e            state;
  port_e             owner;
  port_e             winner;
  logic              any_req;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [CNT_W-1:0]  conflict_cnt;
  logic              in_access, in_resp;
  logic              c_done_int, h_done_int;

  dmem_arb_pick u_pick (
    .clk     (clk),
    .rst_n   (rst_n),
    .c_req   (bus.c_req),
    .h_req   (bus.h_req),
    .upd     (in_access),
    .last    (owner),
    .winner  (winner),
    .any_req (any_req)
  );

  always_comb begin
    // NOTE: give every always_comb output a default first so no path infers a latch.
    sel_we    = bus.c_we;
    sel_addr  = bus.c_addr;
    sel_wdata = bus.c_wdata;
    if (winner == PORT_HOST) begin
      sel_we    = bus.h_we;
      sel_addr  = bus.h_addr;
      sel_wdata = bus.h_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= PORT_CORE;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop sees pre-edge values.
      case (state)
        ACCESS: state <= RESP;
        IDLE, RESP: begin
          // RESP re-arbitrates directly so back-to-back requests take 2 cycles each.
          if (any_req) begin
            state     <= ACCESS;
            owner     <= winner;
            lat_we    <= sel_we;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (bus.c_req && bus.h_req) begin
      conflict_cnt <= sat_inc(conflict_cnt);
    end
  end

  assign dbg_conflict_cnt = conflict_cnt;

  // All strobes decode from registered state, so reset clears them at once.
  assign in_access  = (state == ACCESS);
  assign in_resp    = (state == RESP);
  assign c_done_int = in_resp && (owner == PORT_CORE);
  assign h_done_int = in_resp && (owner == PORT_HOST);

  assign bus.mem_addr  = in_access ? lat_addr  : '0;
  assign bus.mem_wdata = in_access ? lat_wdata : '0;
  assign bus.mem_read  = in_access && !lat_we;
  assign bus.mem_write = in_access &&  lat_we;

  assign bus.c_gnt   = in_access && (owner == PORT_CORE);
  assign bus.h_gnt   = in_access && (owner == PORT_HOST);
  assign bus.c_done  = c_done_int;
  assign bus.h_done  = h_done_int;
  assign bus.c_rdata = (c_done_int && !lat_we) ? bus.mem_rdata : '0;
  assign bus.h_rdata = (h_done_int && !lat_we) ? bus.mem_rdata : '0;

  assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural data_memory model.
// Expected grant order follows DMEM_ARB_RR_EN when defined.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  typedef struct {
    port_e       port;
    logic        we;
    logic [5:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();
  dmem_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_gnt = -1;
  int   wr_pulses = 0;
  bit   sb_en = 1'b1;
  bit   chk_gap = 1'b0;
  txn_t gnt_q[$];
  txn_t done_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_pat(input logic [5:0] a);
    return (a == 6'd5) ? 16'h1234 : {a, 2'b10, ~a, 2'b01};
  endfunction

  // data_memory model: one-cycle read latency
  logic [15:0] mem [64];
  logic        mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int a = 0; a < 64; a++) mem[a] <= mem_pat(6'(a));
      mem_ready <= 1'b1;
    end else begin
      if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_read)  bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pops expectations on grant and on completion.
  always @(negedge clk) begin
    txn_t e;
    if (bus.mem_write) wr_pulses++;
    if (sb_en && (bus.c_gnt || bus.h_gnt)) begin
      check("gnt_excl", 32'(bus.c_gnt && bus.h_gnt), 0);
      if (gnt_q.size() == 0) begin
        check("gnt_unexpected", 1, 0);
      end else begin
        e = gnt_q.pop_front();
        check("gnt_port", 32'(bus.h_gnt), 32'(e.port));
        check("gnt_mem_addr", 32'(bus.mem_addr), 32'(e.addr));
        check("gnt_mem_rw", {30'd0, bus.mem_read, bus.mem_write}, {30'd0, !e.we, e.we});
        if (e.we) check("gnt_mem_wdata", 32'(bus.mem_wdata), 32'(e.wdata));
      end
      if (chk_gap && last_gnt >= 0) check("gnt_gap", 32'(cyc - last_gnt), 2);
      last_gnt = cyc;
    end
    if (sb_en && (bus.c_done || bus.h_done)) begin
      check("done_excl", 32'(bus.c_done && bus.h_done), 0);
      check("done_mem_idle", {30'd0, bus.mem_read, bus.mem_write}, 0);
      check("done_mem_addr", 32'(bus.mem_addr), 0);
      if (done_q.size() == 0) begin
        check("done_unexpected", 1, 0);
      end else begin
        e = done_q.pop_front();
        check("done_port", 32'(bus.h_done), 32'(e.port));
        check("done_rdata", 32'(bus.h_done ? bus.h_rdata : bus.c_rdata), e.we ? 32'd0 : 32'(e.rdata));
        check("loser_rdata", 32'(bus.h_done ? bus.c_rdata : bus.h_rdata), 0);
      end
    end
  end

  task automatic push(input port_e p, input logic we, input logic [5:0] a,
                      input logic [15:0] d, input logic [15:0] r);
    txn_t t;
    t = '{port: p, we: we, addr: a, wdata: d, rdata: r};
    gnt_q.push_back(t);
    done_q.push_back(t);
  endtask

  task automatic set_port(input port_e p, input logic r, input logic we,
                          input logic [5:0] a, input logic [15:0] d);
    if (p == PORT_CORE) begin
      bus.c_req = r; bus.c_we = we; bus.c_addr = a; bus.c_wdata = d;
    end else begin
      bus.h_req = r; bus.h_we = we; bus.h_addr = a; bus.h_wdata = d;
    end
  endtask

  // Issues n requests from one port; returns at the negedge of the last grant.
  task automatic drive(input port_e p, input int n, input logic we, input logic [5:0] a0,
                       input logic [15:0] d0, output int lat);
    lat = -1;
    for (int i = 0; i < n; i++) begin : item
      bit seen;
      int k;
      seen = 1'b0;
      k = 0;
      set_port(p, 1'b1, we, a0 + 6'(i), d0 + 16'(i));
      while (!seen && k < 100) begin
        @(negedge clk);
        seen = (p == PORT_CORE) ? bus.c_gnt : bus.h_gnt;
        k++;
      end
      if (!seen) begin
        check("gnt_timeout", 0, 1);
        i = n;
      end else if (i == 0) begin
        lat = k - 1;
      end
    end
    set_port(p, 1'b0, 1'b0, 6'd0, 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lc, lh, w0;
    set_port(PORT_CORE, 1'b0, 1'b0, 6'd0, 16'd0);
    set_port(PORT_HOST, 1'b0, 1'b0, 6'd0, 16'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_strobes", {26'd0, bus.c_gnt, bus.h_gnt, bus.c_done, bus.h_done, bus.mem_read, bus.mem_write}, 0);
    check("rst_mem_bus", {10'd0, bus.mem_addr, bus.mem_wdata}, 0);
    check("rst_rdata", {bus.c_rdata, bus.h_rdata}, 0);
    check("rst_conflict", 32'(dbg_conflict_cnt), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // core load from address 5
    push(PORT_CORE, 1'b0, 6'd5, 16'd0, 16'h1234);
    drive(PORT_CORE, 1, 1'b0, 6'd5, 16'd0, lat);
    check("load_gnt_lat", 32'(lat), 1);
    check("load_mem_read", 32'(bus.mem_read), 1);
    check("load_mem_addr", 32'(bus.mem_addr), 5);
    check("load_h_gnt", 32'(bus.h_gnt), 0);
    check("load_busy", 32'(bus.busy), 1);
    @(negedge clk);
    check("load_c_done", 32'(bus.c_done), 1);
    check("load_c_rdata", 32'(bus.c_rdata), 32'h1234);
    check("load_h_done", 32'(bus.h_done), 0);
    @(negedge clk);
    check("load_idle", {30'd0, bus.busy, bus.c_done}, 0);

    // host store to the top address, then read it back
    w0 = wr_pulses;
    @(posedge clk); #1;
    push(PORT_HOST, 1'b1, 6'd63, 16'hBEEF, 16'd0);
    drive(PORT_HOST, 1, 1'b1, 6'd63, 16'hBEEF, lat);
    check("store_gnt_lat", 32'(lat), 1);
    check("store_c_gnt", 32'(bus.c_gnt), 0);
    check("store_wdata", 32'(bus.mem_wdata), 32'hBEEF);
    @(negedge clk);
    check("store_h_done", 32'(bus.h_done), 1);
    check("store_h_rdata", 32'(bus.h_rdata), 0);
    check("store_one_write", 32'(wr_pulses - w0), 1);
    @(posedge clk); #1;
    push(PORT_HOST, 1'b0, 6'd63, 16'd0, 16'hBEEF);
    drive(PORT_HOST, 1, 1'b0, 6'd63, 16'd0, lat);
    repeat (2) @(negedge clk);

    // four simultaneous request pairs, back to back
`ifdef DMEM_ARB_RR_EN
    for (int i = 0; i < 4; i++) begin
      push(PORT_CORE, 1'b0, 6'(10 + i), 16'd0, mem_pat(6'(10 + i)));
      push(PORT_HOST, 1'b0, 6'(20 + i), 16'd0, mem_pat(6'(20 + i)));
    end
`else
    for (int i = 0; i < 4; i++) push(PORT_CORE, 1'b0, 6'(10 + i), 16'd0, mem_pat(6'(10 + i)));
    for (int i = 0; i < 4; i++) push(PORT_HOST, 1'b0, 6'(20 + i), 16'd0, mem_pat(6'(20 + i)));
`endif
    chk_gap = 1'b1;
    last_gnt = -1;
    @(posedge clk); #1;
    fork
      drive(PORT_CORE, 4, 1'b0, 6'd10, 16'd0, lc);
      drive(PORT_HOST, 4, 1'b0, 6'd20, 16'd0, lh);
    join
    repeat (3) @(negedge clk);
    chk_gap = 1'b0;
    check("pair_conflict_nz", 32'(dbg_conflict_cnt != 0), 1);

    // conflict counter saturation
    sb_en = 1'b0;
    @(posedge clk); #1;
    set_port(PORT_CORE, 1'b1, 1'b0, 6'd0, 16'd0);
    set_port(PORT_HOST, 1'b1, 1'b0, 6'd1, 16'd0);
    repeat (300) @(negedge clk);
    check("cnt_saturate", 32'(dbg_conflict_cnt), 255);
    repeat (20) @(negedge clk);
    check("cnt_no_wrap", 32'(dbg_conflict_cnt), 255);
    set_port(PORT_CORE, 1'b0, 1'b0, 6'd0, 16'd0);
    set_port(PORT_HOST, 1'b0, 1'b0, 6'd0, 16'd0);
    repeat (4) @(negedge clk);
    check("sat_idle", 32'(bus.busy), 0);
    sb_en = 1'b1;

    // reset during ACCESS of a load: grant expected, completion must not appear
    @(posedge clk); #1;
    gnt_q.push_back('{port: PORT_CORE, we: 1'b0, addr: 6'd7, wdata: 16'd0, rdata: 16'd0});
    drive(PORT_CORE, 1, 1'b0, 6'd7, 16'd0, lat);
    #2 rst_n = 1'b0;
    #1;
    check("rst_acc_busy", 32'(bus.busy), 0);
    check("rst_acc_strobes", {29'd0, bus.c_gnt, bus.mem_read, bus.c_done}, 0);
    @(negedge clk);
    check("rst_acc_no_done", {30'd0, bus.c_done, bus.busy}, 0);
    check("rst_acc_cnt_clr", 32'(dbg_conflict_cnt), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    push(PORT_CORE, 1'b0, 6'd9, 16'd0, mem_pat(6'd9));
    drive(PORT_CORE, 1, 1'b0, 6'd9, 16'd0, lat);
    check("post_rst_gnt_lat", 32'(lat), 1);
    repeat (3) @(negedge clk);

    check("gnt_q_drained", 32'(gnt_q.size()), 0);
    check("done_q_drained", 32'(done_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 ADDR_W, default 6, SHALL set the data-memory word-address width.
REQ-002 DATA_W, default 16, SHALL set the data-memory word width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 c_req, c_we  input  1 each  SHALL carry the core port request and write-enable (1=store, 0=load).
REQ-006 c_addr  input  ADDR_W, c_wdata  input  DATA_W  SHALL carry the core port address and store data.
REQ-007 c_gnt, c_done  output  1 each  SHALL carry the core port accept pulse and completion pulse.
REQ-008 c_rdata  output  DATA_W  SHALL carry the core port load data, valid only while c_done=1 on a load.
REQ-009 h_req, h_we, h_addr, h_wdata, h_gnt, h_done, h_rdata SHALL form the host/loader port, with the same widths and meanings as the core port.
REQ-010 mem_addr  output  ADDR_W, mem_wdata  output  DATA_W, mem_read  output  1, mem_write  output  1  SHALL drive data_memory.
REQ-011 mem_rdata  input  DATA_W  SHALL return data_memory read data one cycle after mem_read=1.
REQ-012 busy  output  1  SHALL be 1 in any state other than IDLE.

Function
REQ-013 FSM states SHALL be IDLE, ACCESS and RESP, held in a registered state variable.
REQ-014 IDLE: if c_req or h_req is 1 on an edge, the arbiter SHALL pick a winner, latch its we/addr/wdata, record the winner, and go to ACCESS; otherwise it stays in IDLE.
REQ-015 ACCESS (one cycle): the arbiter SHALL drive mem_addr/mem_wdata from the latch, mem_read=~we, mem_write=we, and pulse the winner's gnt; it then goes to RESP.
REQ-016 RESP (one cycle): the arbiter SHALL pulse the winner's done and drive its rdata from mem_rdata (0 on stores); mem_read/mem_write SHALL be 0.
REQ-017 RESP exit: with any req=1, the arbiter SHALL arbitrate as in IDLE and go straight to ACCESS; otherwise it SHALL go to IDLE.
REQ-018 Throughput SHALL be one transaction per 2 cycles back-to-back; single-request latency req→done SHALL be 3 edges.
REQ-019 Requesters SHALL hold req/we/addr/wdata stable until gnt; req still high in the cycle after gnt SHALL count as a new request.
REQ-020 gnt, done and mem_read/mem_write SHALL be single-cycle pulses and mutually exclusive between ports.
REQ-021 The non-winning port's gnt/done/rdata SHALL be 0.
REQ-022 Default arbitration SHALL be fixed priority, core over host.
REQ-023 mem_addr/mem_wdata SHALL be 0 outside ACCESS.
REQ-024 conflict counter (internal, 8-bit, saturating at 255): SHALL increment each cycle c_req=h_req=1 while a port is not granted; it is observable through the package debug hook only.

Reset
REQ-025 Asserting reset (low) SHALL asynchronously force IDLE, all outputs 0, the latches and conflict counter to 0, and the priority pointer to core.
REQ-026 Reset during ACCESS or RESP SHALL abandon the transaction with no done pulse; a write already pulsed in ACCESS is not undone.
REQ-027 After reset deasserts, the first arbitration SHALL occur on the first rising edge.

Configuration
REQ-028 Macro DMEM_ARB_RR_EN defined: arbitration SHALL be round-robin with a 1-bit last-winner pointer updated in ACCESS; on a simultaneous request, the port that did not win last SHALL win.
REQ-029 DMEM_ARB_RR_EN undefined: arbitration SHALL be fixed priority per REQ-022 and no pointer flop SHALL exist.

Structure
REQ-030 Package dmem_arb_pkg SHALL hold ADDR_W/DATA_W defaults, the state enum (IDLE/ACCESS/RESP) and the port-id typedef (PORT_CORE/PORT_HOST).
REQ-031 One sub-module, dmem_arb_pick (combinational winner select plus the RR pointer under the macro), SHALL be instantiated; the rest is flat.

Verification
REQ-032 Core load: c_req=1, c_we=0, c_addr=5, mem[5]=0x1234 -> mem_read in ACCESS at mem_addr=5; c_done with c_rdata=0x1234 on edge 3; h_* stay 0.
REQ-033 Host store: h_we=1, h_addr=63, h_wdata=0xBEEF -> one mem_write pulse at addr 63 with data 0xBEEF; h_done one cycle later; c_gnt=0.
REQ-034 Simultaneous req, macro off, 4 back-to-back pairs -> all core transactions are granted before any host transaction; conflict counter nonzero.
REQ-035 Simultaneous req, DMEM_ARB_RR_EN on -> grants alternate core, host, core, host at a 2-cycle spacing.
REQ-036 Reset pulled low in ACCESS of a load -> next cycle IDLE, busy=0, no c_done; a new request after release completes normally.
REQ-037 Conflict counter: both ports held requesting for 300 cycles -> counter saturates at 255 and does not wrap.
